// File: rtl/scheduler_pkg.sv
// Shared constants, packet field positions and FSM state type for the
// spike scheduler controller.
package scheduler_pkg;

    localparam int NUM_AXONS = 256;
    localparam int AXON_W    = 8;
    localparam int NUM_SLOTS = 16;
    localparam int SLOT_W    = 4;

    // Router packet layout: [11:4] axon, [3:0] delay
    localparam int PKT_W     = 12;
    localparam int AXON_MSB  = 11;
    localparam int AXON_LSB  = 4;
    localparam int DELAY_MSB = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        ADV  = 2'd3
    } state_t;

endpackage

// File: rtl/scheduler_controller_if.sv
// Bundle of tick, router packet, SRAM and neuron-core event signals around
// the scheduler controller. The controller uses master; the surrounding core uses slave.
interface scheduler_controller_if;
    import scheduler_pkg::*;

    logic                 tick;
    logic                 pkt_valid;
    logic [PKT_W-1:0]     pkt_data;
    logic                 pkt_ready;
    logic [SLOT_W-1:0]    sram_read_address;
    logic [NUM_AXONS-1:0] sram_out;
    logic                 sram_clr;
    logic                 sram_wen;
    logic [PKT_W-1:0]     sram_packet;
    logic                 evt_valid;
    logic [AXON_W-1:0]    evt_axon;
    logic                 evt_ready;
    logic                 step_done;
    logic                 busy;
    logic                 tick_overrun;

    modport master (
        input  tick, pkt_valid, pkt_data, sram_out, evt_ready,
        output pkt_ready, sram_read_address, sram_clr, sram_wen, sram_packet,
               evt_valid, evt_axon, step_done, busy, tick_overrun
    );

    modport slave (
        output tick, pkt_valid, pkt_data, sram_out, evt_ready,
        input  pkt_ready, sram_read_address, sram_clr, sram_wen, sram_packet,
               evt_valid, evt_axon, step_done, busy, tick_overrun
    );

endinterface

// File: rtl/lsb_priority_encoder.sv
// Returns the index of the lowest set bit of vec, plus whether any bit is set.
module lsb_priority_encoder #(
    parameter int WIDTH = 256,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             any_set
);

    always_comb begin
        // NOTE: default assigned before the loop so every path drives index and no latch is inferred.
        index = '0;
        // Scanning downwards lets the lowest set bit be the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) index = IDX_W'(i);
        end
    end

    assign any_set = |vec;

endmodule

// File: rtl/scheduler_controller.sv
// Per-time-step sequencer for the spike scheduler SRAM: latch and clear the current
// slot, stream its set bits as axon events, then advance the slot pointer.
module scheduler_controller
    import scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    scheduler_controller_if.master bus
);

    state_t               state;
    logic [NUM_AXONS-1:0] scan_reg;
    logic [SLOT_W-1:0]    rd_addr;
    logic                 overrun;
    logic [AXON_W-1:0]    lsb_idx;
    logic                 lsb_any;

    lsb_priority_encoder #(
        .WIDTH (NUM_AXONS),
        .IDX_W (AXON_W)
    ) u_lsb_enc (
        .vec     (scan_reg),
        .index   (lsb_idx),
        .any_set (lsb_any)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            scan_reg <= '0;
            rd_addr  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (bus.tick && state != IDLE) overrun <= 1'b1;
            unique case (state)
                IDLE: if (bus.tick) state <= LOAD;
                LOAD: begin
                    scan_reg <= bus.sram_out;
                    state    <= SCAN;
                end
                SCAN: begin
                    if (!lsb_any)           state <= ADV;
                    else if (bus.evt_ready) scan_reg[lsb_idx] <= 1'b0;
                end
                ADV: begin
                    rd_addr <= rd_addr + SLOT_W'(1);
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Blocking writes in LOAD keeps router writes away from the slot-clear cycle;
    // reset gating keeps every output low while reset is held.
    assign bus.pkt_ready         = !reset && (state != LOAD);
    assign bus.sram_wen          = bus.pkt_valid && bus.pkt_ready;
    assign bus.sram_packet       = bus.pkt_data;
    assign bus.sram_read_address = rd_addr;
    assign bus.sram_clr          = (state == LOAD);
    assign bus.evt_valid         = (state == SCAN) && lsb_any;
    assign bus.evt_axon          = bus.evt_valid ? lsb_idx : '0;
    assign bus.step_done         = (state == ADV);
    assign bus.busy              = (state != IDLE);
    assign bus.tick_overrun      = overrun;

endmodule

// File: tb/tb_scheduler_controller.sv
// Directed bench for scheduler_controller with a behavioural 16x256 scheduler SRAM.
module tb_scheduler_controller;
    import scheduler_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    scheduler_controller_if bus ();

    scheduler_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Scheduler SRAM: write slot = read_address + delay + 1 (mod 16)
    logic [NUM_AXONS-1:0] mem [NUM_SLOTS];
    logic [SLOT_W-1:0]    wr_slot;

    assign bus.sram_out = mem[bus.sram_read_address];
    assign wr_slot      = bus.sram_read_address + bus.sram_packet[DELAY_MSB:0] + SLOT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
        end else begin
            if (bus.sram_clr) mem[bus.sram_read_address] <= '0;
            if (bus.sram_wen) mem[wr_slot][bus.sram_packet[AXON_MSB:AXON_LSB]] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic write_pkt(input logic [PKT_W-1:0] p);
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = p;
        cyc();
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
    endtask

    // One full step with whatever evt_ready is currently driven; bounded wait.
    task automatic run_step(output int lat, output int nevt, output logic [AXON_W-1:0] axon);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        lat  = 1;
        nevt = 0;
        axon = '0;
        while (!bus.step_done && lat < 40) begin
            if (bus.evt_valid && bus.evt_ready) begin
                nevt++;
                axon = bus.evt_axon;
            end
            cyc();
            lat++;
        end
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int                lat;
        int                nevt;
        int                exp_evt;
        logic [AXON_W-1:0] ax;
        logic [SLOT_W-1:0] slot;

        bus.tick      = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        bus.evt_ready = 1'b0;

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_addr", 32'(bus.sram_read_address), 32'd0);
        check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_step_done", 32'(bus.step_done), 32'd0);
        check("rst_sram_clr", 32'(bus.sram_clr), 32'd0);
        check("rst_overrun", 32'(bus.tick_overrun), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        check("idle_pkt_ready", 32'(bus.pkt_ready), 32'd1);

        // 1: empty slot 0
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check("t1_load_clr", 32'(bus.sram_clr), 32'd1);
        check("t1_load_busy", 32'(bus.busy), 32'd1);
        cyc();
        check("t1_scan_evt_valid", 32'(bus.evt_valid), 32'd0);
        check("t1_scan_step_done", 32'(bus.step_done), 32'd0);
        cyc();
        check("t1_step_done", 32'(bus.step_done), 32'd1);
        check("t1_addr_in_adv", 32'(bus.sram_read_address), 32'd0);
        cyc();
        check("t1_addr_after", 32'(bus.sram_read_address), 32'd1);
        check("t1_idle", 32'(bus.busy), 32'd0);

        // 2: slot 1 holds axons 3, 200, 255 (delay 15 lands in the current slot)
        write_pkt(12'h03F);
        write_pkt(12'hC8F);
        write_pkt(12'hFFF);
        bus.evt_ready = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check("t2_clr_tick1", 32'(bus.sram_clr), 32'd1);
        check("t2_load_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        cyc();
        check("t2_evt0_valid", 32'(bus.evt_valid), 32'd1);
        check("t2_evt0_axon", 32'(bus.evt_axon), 32'd3);
        cyc();
        check("t2_evt1_axon", 32'(bus.evt_axon), 32'd200);
        cyc();
        check("t2_evt2_axon", 32'(bus.evt_axon), 32'd255);
        cyc();
        check("t2_drained", 32'(bus.evt_valid), 32'd0);
        check("t2_no_done_yet", 32'(bus.step_done), 32'd0);
        cyc();
        check("t2_step_done_tick6", 32'(bus.step_done), 32'd1);
        cyc();
        check("t2_addr_after", 32'(bus.sram_read_address), 32'd2);

        // 3: backpressure on axon 17 in slot 2
        write_pkt(12'h11F);
        bus.evt_ready = 1'b0;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold%0d_valid", i), 32'(bus.evt_valid), 32'd1);
            check($sformatf("t3_hold%0d_axon", i), 32'(bus.evt_axon), 32'd17);
            cyc();
        end
        bus.evt_ready = 1'b1;
        #1;
        check("t3_accept_axon", 32'(bus.evt_axon), 32'd17);
        cyc();
        check("t3_single_event", 32'(bus.evt_valid), 32'd0);
        cyc();
        check("t3_step_done", 32'(bus.step_done), 32'd1);
        cyc();
        check("t3_addr_after", 32'(bus.sram_read_address), 32'd3);

        // 4: packet 0x0A2 offered in the LOAD cycle of slot 3
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = 12'h0A2;
        #1;
        check("t4_load_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        check("t4_load_wen", 32'(bus.sram_wen), 32'd0);
        check("t4_load_clr", 32'(bus.sram_clr), 32'd1);
        cyc();
        check("t4_scan_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        check("t4_scan_wen", 32'(bus.sram_wen), 32'd1);
        check("t4_scan_packet", 32'(bus.sram_packet), 32'h0A2);
        cyc();
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        check("t4_step_done", 32'(bus.step_done), 32'd1);
        cyc();
        check("t4_addr_after", 32'(bus.sram_read_address), 32'd4);

        // 5: sixteen steps from slot 4; the 0x0A2 packet surfaces in slot 6
        for (int s = 0; s < 16; s++) begin
            slot = SLOT_W'(4 + s);
            run_step(lat, nevt, ax);
            exp_evt = (slot == 4'd6) ? 1 : 0;
            check($sformatf("t5_slot%0d_events", slot), 32'(nevt), 32'(exp_evt));
            check($sformatf("t5_slot%0d_latency", slot), 32'(lat), 32'(3 + exp_evt));
            if (slot == 4'd6) check("t5_slot6_axon", 32'(ax), 32'd10);
            check($sformatf("t5_slot%0d_next_addr", slot), 32'(bus.sram_read_address),
                  32'(SLOT_W'(slot + 4'd1)));
        end

        // 5b: tick mid-SCAN on slot 4 (axons 1, 2) is ignored and sets overrun
        write_pkt(12'h01F);
        write_pkt(12'h02F);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        check("t5b_evt_axon1", 32'(bus.evt_axon), 32'd1);
        bus.tick = 1'b1;
        #1;
        check("t5b_overrun_before", 32'(bus.tick_overrun), 32'd0);
        cyc();
        bus.tick = 1'b0;
        check("t5b_overrun_set", 32'(bus.tick_overrun), 32'd1);
        check("t5b_evt_axon2", 32'(bus.evt_axon), 32'd2);
        cyc();
        check("t5b_drained", 32'(bus.evt_valid), 32'd0);
        cyc();
        check("t5b_step_done", 32'(bus.step_done), 32'd1);
        cyc();
        check("t5b_addr_after", 32'(bus.sram_read_address), 32'd5);
        cyc();
        check("t5b_tick_ignored", 32'(bus.busy), 32'd0);
        check("t5b_overrun_sticky", 32'(bus.tick_overrun), 32'd1);

        // 6: reset during SCAN of slot 5 with axons 7 and 9 pending
        write_pkt(12'h07F);
        write_pkt(12'h09F);
        bus.evt_ready = 1'b0;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        check("t6_pending_axon", 32'(bus.evt_axon), 32'd7);
        reset = 1'b1;
        #1;
        check("t6_rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_addr", 32'(bus.sram_read_address), 32'd0);
        check("t6_rst_overrun", 32'(bus.tick_overrun), 32'd0);
        check("t6_rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        check("t6_after_rst_idle", 32'(bus.busy), 32'd0);
        write_pkt(12'h2AF);
        bus.evt_ready = 1'b1;
        run_step(lat, nevt, ax);
        check("t6_slot0_events", 32'(nevt), 32'd1);
        check("t6_slot0_axon", 32'(ax), 32'd42);
        check("t6_slot0_latency", 32'(lat), 32'd4);
        check("t6_addr_after", 32'(bus.sram_read_address), 32'd1);

        // tick coinciding with ADV counts as overrun and starts nothing
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        cyc();
        check("adv_step_done", 32'(bus.step_done), 32'd1);
        check("adv_overrun_before", 32'(bus.tick_overrun), 32'd0);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check("adv_overrun_set", 32'(bus.tick_overrun), 32'd1);
        check("adv_tick_ignored", 32'(bus.busy), 32'd0);
        check("adv_addr_after", 32'(bus.sram_read_address), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
